// File: rtl/shift_add_mult_ctrl.sv
// Control FSM sequencing a left-shift shift-and-add multiply over two universal registers (P, M).
// Optional feature: define MULT_ABORT_EN to add an abort input that cancels an operation in INIT/SHIFT/ADD.
module shift_add_mult_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
`ifdef MULT_ABORT_EN
    input  logic             abort,
`endif
    input  logic             mplr_msb,
    output logic [1:0]       prod_mode,
    output logic [1:0]       mplr_mode,
    output logic             prod_ld_sel,
    output logic             prod_sin,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_SHIFT = 3'd2,
        S_ADD   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHIFT = 2'b01;
    localparam logic [1:0] MODE_LOAD  = 2'b11;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic             msb_q, msb_d;
    logic             abort_s;

`ifdef MULT_ABORT_EN
    assign abort_s = abort && ((state_q == S_INIT) || (state_q == S_SHIFT) || (state_q == S_ADD));
`else
    assign abort_s = 1'b0;
`endif

    // State, iteration counter and captured multiplier bit
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            msb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            msb_q   <= msb_d;
        end
    end

    // Next-state logic; M holds during SHIFT, so its msb captured there equals the value seen in ADD
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        msb_d   = msb_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                    iter_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT: begin
                state_d = S_SHIFT;
                iter_d  = '0;
            end
            S_SHIFT: begin
                state_d = S_ADD;
                msb_d   = mplr_msb;
            end
            S_ADD: begin
                if (iter_q == LAST_ITER) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SHIFT;
                    iter_d  = iter_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_s) begin
            state_d = S_IDLE;
            iter_d  = iter_q;
            msb_d   = msb_q;
        end else begin
            state_d = state_d;
        end
    end

    // Mode decode from the current state and the bit captured in SHIFT
    always_comb begin
        prod_mode   = MODE_HOLD;
        mplr_mode   = MODE_HOLD;
        prod_ld_sel = 1'b0;
        case (state_q)
            S_INIT: begin
                prod_mode = MODE_LOAD;
                mplr_mode = MODE_LOAD;
            end
            S_SHIFT: prod_mode = MODE_SHIFT;
            S_ADD: begin
                mplr_mode = MODE_SHIFT;
                if (msb_q) begin
                    prod_mode   = MODE_LOAD;
                    prod_ld_sel = 1'b1;
                end else begin
                    prod_mode   = MODE_HOLD;
                end
            end
            default: prod_mode = MODE_HOLD;
        endcase
        if (abort_s) begin
            prod_mode   = MODE_HOLD;
            mplr_mode   = MODE_HOLD;
            prod_ld_sel = 1'b0;
        end else begin
            prod_ld_sel = prod_ld_sel;
        end
    end

    assign prod_sin = 1'b0;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign iter     = iter_q;

endmodule

// File: doc/shift_add_mult_ctrl.md
Name: shift_add_mult_ctrl

Overview:
- Control FSM that sequences a left-shift shift-and-add multiply.
- Drives the 2-bit mode inputs of two 16-bit universal registers: the product register (P) and the multiplier register (M). The multiplicand lives in a holding register, and a 16-bit adder produces P + A.
- Sits directly upstream of the universal registers: this block produces every mode code they consume, and it consumes M's serial output, which is M bit 15.
- Universal register mode codes: 00 = hold, 01 = shift left (serial in enters bit 0), 10 = increment, 11 = parallel load.

Parameters:
- WIDTH, 16, operand width; also the number of iterations.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  reset
- start  input  1  request a multiply; sampled only in IDLE
- mplr_msb  input  1  serial output of M (M[WIDTH-1])
- prod_mode  output  2  mode code to P register
- mplr_mode  output  2  mode code to M register
- prod_ld_sel  output  1  P load-data mux select: 0 = all zeros, 1 = adder sum (P + A)
- prod_sin  output  1  P serial input; constant 0
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the product is valid in P
- iter  output  CNT_W  current iteration index

Behaviour:
- Reset and clocking:
  - clk is the only clock. clr is synchronous and active-high.
  - On reset: state = IDLE, iter = 0, prod_mode = 00, mplr_mode = 00, prod_ld_sel = 0, busy = 0, done = 0.
- All outputs are registered or pure state decodes. Mode codes must be valid during the cycle whose closing edge they act on.
- States:
  - IDLE: modes 00. start = 1 moves to INIT at the next edge.
  - INIT (1 cycle): prod_mode = 11 with prod_ld_sel = 0, so P is cleared. mplr_mode = 11, so M loads the multiplier operand. iter cleared to 0. Next state: SHIFT.
  - SHIFT (1 cycle): prod_mode = 01, so P is shifted left with a 0 entering. mplr_mode = 00. Next state: ADD.
  - ADD (1 cycle):
    - If mplr_msb = 1: prod_mode = 11 with prod_ld_sel = 1, so P loads P + A. Otherwise prod_mode = 00.
    - mplr_mode = 01 (M shifts left, exposing the next bit). iter increments.
    - If iter == WIDTH-1, next state is DONE; otherwise SHIFT.
  - DONE (1 cycle): done = 1, modes 00. Next state: IDLE.
- Sampling rule: mplr_msb is sampled in ADD before the M shift takes effect. The first SHIFT acts on P = 0, so it is harmless.
- Latency: start is seen high at edge E0. INIT occupies the cycle after E0, then 2*WIDTH cycles of SHIFT/ADD, then DONE. done is high in cycle 2*WIDTH+2 after E0 (cycle 34 for WIDTH = 16).
- Back-to-back: start high during DONE is ignored. A new start is accepted the cycle after DONE, i.e. in IDLE.
- start while busy is ignored, with no queueing.
- clr mid-operation returns to IDLE on that edge. done is not pulsed. P and M contents are left to their own reset.
- Arithmetic: the product is truncated to WIDTH bits (the low half). Adder carry-out is discarded.
- iter never exceeds WIDTH-1 and never wraps.

Optional Feature:
- Macro: MULT_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort = 1 in INIT, SHIFT or ADD forces state to IDLE at the next edge, with all modes 00 in that cycle and no done pulse.
  - abort in IDLE or DONE is ignored.
- Not defined: the port is absent and the FSM is as above.

Test Plan:
- Reset: hold clr high 2 cycles with start = 1 -> busy = 0, done = 0, prod_mode = 00, mplr_mode = 00, iter = 0.
- Basic multiply: A = 3, multiplier = 5, start pulse -> done exactly 34 cycles after start is sampled; P = 15; exactly 2 ADD cycles with prod_mode = 11.
- Full ones: A = 16'hFFFF, multiplier = 16'hFFFF -> P = 16'h0001 (truncated); 16 add loads; no iter wrap.
- Zero multiplier: multiplier = 0, A = 16'h1234 -> P = 0; prod_mode never 11 with prod_ld_sel = 1; done on cycle 34.
- Busy and restart: start re-asserted during SHIFT -> ignored, with single done. Then start asserted in the cycle after done -> new multiply A = 7, multiplier = 9 gives P = 63.
- Reset and abort: clr asserted at iteration 8 -> IDLE next cycle, no done. With MULT_ABORT_EN defined, abort in ADD at iteration 4 -> IDLE, no done; a following 2 × 2 multiply gives P = 4.
